// File: rtl/audio_pkg.sv
// Shared types, constants and the sample saturation helper for the
// audio output serializer.
package audio_pkg;

   localparam int UNDERFLOW_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT_L,
      SHIFT_R
   } ser_state_t;

   // Clamp a sign-extended sample into the signed range of 'bits' bits.
   // The caller keeps the low 'bits' bits of the result.
   function automatic logic [63:0] saturate(input logic signed [63:0] x,
                                            input int bits);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/audio_out_serializer_if.sv
// FIFO read port plus serial DAC lines between the audio output FIFOs,
// the serializer and the board DAC.
interface audio_out_serializer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] left_dout;
   logic                  left_empty;
   logic [DATA_WIDTH-1:0] right_dout;
   logic                  right_empty;
   logic                  out_rd_en;
   logic                  bclk;
   logic                  lrclk;
   logic                  sdata;

   modport master (
      input  left_dout,
      input  left_empty,
      input  right_dout,
      input  right_empty,
      output out_rd_en,
      output bclk,
      output lrclk,
      output sdata
   );

   modport slave (
      output left_dout,
      output left_empty,
      output right_dout,
      output right_empty,
      input  out_rd_en,
      input  bclk,
      input  lrclk,
      input  sdata
   );
endinterface

// File: rtl/audio_out_serializer_bclk_divider.sv
// Bit-clock generator: divides the system clock while 'run' is high and
// flags the cycle on which bclk is about to rise or fall.
module bclk_divider #(
   parameter int CLK_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   output logic bclk,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] div_cnt;
   logic          tick;

   assign tick      = run && (div_cnt == CW'(CLK_DIV - 1));
   assign rise_tick = tick && !bclk;
   assign fall_tick = tick && bclk;

   // Counter and bclk both park at zero whenever the serializer is not shifting.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (!run) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/audio_out_serializer.sv
// Pops one left/right pair per frame from the audio FIFOs and sends it to
// the DAC as a left-justified, MSB-first serial stream.
module audio_out_serializer
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SAMPLE_BITS = 16,
   parameter int CLK_DIV     = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   audio_out_serializer_if.master aud,
   output logic                   busy,
   output logic [UNDERFLOW_W-1:0] underflow_cnt
);

   localparam int BIT_CNT_W  = $clog2(SAMPLE_BITS);
   localparam int FRAME_BITS = 2 * SAMPLE_BITS;

   ser_state_t             state;
   logic [FRAME_BITS-1:0]  shift_q;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic                   lrclk_q;
   logic [UNDERFLOW_W-1:0] underflow_q;

   logic run;
   logic bclk;
   logic fall_tick;
   logic rise_tick_unused;
   logic last_bit;
   logic pair_ready;

   assign run        = (state == SHIFT_L) || (state == SHIFT_R);
   assign last_bit   = (bit_cnt == BIT_CNT_W'(SAMPLE_BITS - 1));
   assign pair_ready = !aud.left_empty && !aud.right_empty;

   bclk_divider #(
      .CLK_DIV(CLK_DIV)
   ) u_div (
      .clock    (clock),
      .reset    (reset),
      .run      (run),
      .bclk     (bclk),
      .rise_tick(rise_tick_unused),
      .fall_tick(fall_tick)
   );

   // A pop is only ever issued for a complete pair, and only in LOAD.
   assign aud.out_rd_en = (state == LOAD) && pair_ready;
   assign aud.bclk      = bclk;
   assign aud.lrclk     = lrclk_q;
   assign aud.sdata     = shift_q[FRAME_BITS-1];
   assign busy          = (state != IDLE);
   assign underflow_cnt = underflow_q;

   // Frame sequencer. The left and right samples share one shift register,
   // so the right MSB reaches the output exactly when the left LSB leaves.
   // Data and lrclk move only on falling ticks, keeping them stable across
   // every rising bclk edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         shift_q     <= '0;
         bit_cnt     <= '0;
         lrclk_q     <= 1'b0;
         underflow_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) state <= LOAD;
            end

            LOAD: begin
               state   <= SHIFT_L;
               bit_cnt <= '0;
               lrclk_q <= 1'b0;
               if (pair_ready) begin
                  shift_q <= {SAMPLE_BITS'(saturate(64'(signed'(aud.left_dout[DATA_WIDTH-1:0])), SAMPLE_BITS)),
                              SAMPLE_BITS'(saturate(64'(signed'(aud.right_dout[DATA_WIDTH-1:0])), SAMPLE_BITS))};
               end else begin
                  shift_q <= '0;
                  if (underflow_q != '1) underflow_q <= underflow_q + UNDERFLOW_W'(1);
               end
            end

            SHIFT_L, SHIFT_R: begin
               if (fall_tick) begin
                  shift_q <= shift_q << 1;
                  bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                  if (last_bit) begin
                     bit_cnt <= '0;
                     if (state == SHIFT_L) begin
                        state   <= SHIFT_R;
                        lrclk_q <= 1'b1;
                     end else begin
                        state   <= enable ? LOAD : IDLE;
                        lrclk_q <= 1'b0;
                        shift_q <= '0;
                     end
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_out_serializer.sv
// Self-checking bench for audio_out_serializer: FIFO model, frame-level
// reference model, per-cycle comparison and directed literal checks.
module tb_audio_out_serializer;

   localparam int DW         = 32;
   localparam int SB         = 16;
   localparam int CD         = 4;
   localparam int K_LAST     = 2 * SB * 2 * CD;
   localparam int FRAME_CLKS = K_LAST + 1;

   logic        clock  = 1'b0;
   logic        reset  = 1'b1;
   logic        enable = 1'b0;
   logic        busy;
   logic [15:0] underflow_cnt;

   audio_out_serializer_if #(.DATA_WIDTH(DW)) aud ();

   audio_out_serializer #(
      .DATA_WIDTH (DW),
      .SAMPLE_BITS(SB),
      .CLK_DIV    (CD)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .aud          (aud),
      .busy         (busy),
      .underflow_cnt(underflow_cnt)
   );

   always #5 clock = ~clock;

   // Bench state: FIFO contents, captured serial bits, pop log, counters.
   logic [31:0] lq[$];
   logic [31:0] rq[$];
   logic [1:0]  cap[$];
   int          pop_cycle[$];
   int          pop_count = 0;
   int          cycle     = 0;
   int          total     = 0;
   int          bad       = 0;

   // Reference model: whether a frame is running and the clock offset in it.
   bit              m_active = 1'b0;
   int              m_k      = 0;
   int              m_uf     = 0;
   logic [2*SB-1:0] m_word   = '0;

   function automatic logic [SB-1:0] ref_sat(input logic [31:0] w);
      longint      v;
      longint      hi;
      longint      lo;
      logic [63:0] r;
      v  = longint'(signed'(w));
      hi = (longint'(1) << (SB - 1)) - 1;
      lo = -hi - 1;
      if (v > hi)      r = 64'(hi);
      else if (v < lo) r = 64'(lo);
      else             r = 64'(v);
      return r[SB-1:0];
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_heads();
      aud.left_empty  = (lq.size() == 0);
      aud.right_empty = (rq.size() == 0);
      aud.left_dout   = (lq.size() != 0) ? lq[0] : 32'h0;
      aud.right_dout  = (rq.size() != 0) ? rq[0] : 32'h0;
   endtask

   task automatic apply_stimulus(input logic [31:0] l, input logic [31:0] r);
      lq.push_back(l);
      rq.push_back(r);
      drive_heads();
   endtask

   task automatic set_enable(input logic v);
      @(posedge clock);
      #2;
      enable = v;
   endtask

   task automatic wait_pops(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (pop_count < target && n < budget) begin
         @(negedge clock);
         n++;
      end
      check_output(name, 64'(pop_count >= target), 64'(1));
   endtask

   task automatic wait_busy(input logic level, input int budget, input string name);
      int n;
      n = 0;
      while (busy !== level && n < budget) begin
         @(negedge clock);
         n++;
      end
      check_output(name, 64'(busy), 64'(level));
   endtask

   task automatic check_frame(input int idx, input logic [15:0] el, input logic [15:0] er, input string name);
      logic [15:0] gl;
      logic [15:0] gr;
      logic [1:0]  e;
      int          lr_bad;
      gl     = '0;
      gr     = '0;
      lr_bad = 0;
      if (cap.size() < (idx + 1) * 32) begin
         check_output({name, "_bits"}, 64'(cap.size()), 64'((idx + 1) * 32));
         return;
      end
      for (int i = 0; i < 32; i++) begin
         e = cap[idx * 32 + i];
         if (i < 16) gl = {gl[14:0], e[0]};
         else        gr = {gr[14:0], e[0]};
         if (e[1] !== (i >= 16)) lr_bad++;
      end
      check_output({name, "_left"},  64'(gl), 64'(el));
      check_output({name, "_right"}, 64'(gr), 64'(er));
      check_output({name, "_lrclk"}, 64'(lr_bad), 64'(0));
   endtask

   initial forever begin
      @(posedge clock);
      cycle++;
   end

   // FIFO model: a pop seen mid-LOAD is applied just after the clock edge.
   initial forever begin
      @(negedge clock);
      if (aud.out_rd_en === 1'b1) begin
         check_output("pop_nonempty", 64'(lq.size() > 0 && rq.size() > 0), 64'(1));
         pop_count++;
         pop_cycle.push_back(cycle);
         @(posedge clock);
         #1;
         if (lq.size() > 0) void'(lq.pop_front());
         if (rq.size() > 0) void'(rq.pop_front());
         drive_heads();
      end
   end

   initial forever begin
      @(posedge aud.bclk);
      cap.push_back({aud.lrclk, aud.sdata});
   end

   // Model step: a frame is LOAD (k=0) followed by K_LAST shift clocks.
   initial forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
         m_active = 1'b0;
         m_k      = 0;
         m_uf     = 0;
         m_word   = '0;
      end else if (!m_active) begin
         if (enable) begin
            m_active = 1'b1;
            m_k      = 0;
         end
      end else if (m_k == 0) begin
         if (lq.size() > 0 && rq.size() > 0) begin
            m_word = {ref_sat(lq[0]), ref_sat(rq[0])};
         end else begin
            m_word = '0;
            if (m_uf < 65535) m_uf++;
         end
         m_k = 1;
      end else if (m_k == K_LAST) begin
         if (enable) m_k = 0;
         else        m_active = 1'b0;
      end else begin
         m_k++;
      end
   end

   // Per-cycle comparison of every output against the model.
   initial forever begin
      int   j;
      int   b;
      int   p;
      logic eb, el, es, ebusy, erd;
      @(negedge clock);
      if (!reset) begin
         if (!m_active) begin
            {eb, el, es, ebusy, erd} = 5'b0;
         end else if (m_k == 0) begin
            {eb, el, es, ebusy} = 4'b0001;
            erd = (lq.size() > 0 && rq.size() > 0);
         end else begin
            j     = m_k - 1;
            b     = j / (2 * CD);
            p     = j % (2 * CD);
            eb    = (p >= CD);
            el    = (b >= SB);
            es    = m_word[2*SB-1-b];
            ebusy = 1'b1;
            erd   = 1'b0;
         end
         check_output("per_cycle",
                      64'({aud.bclk, aud.lrclk, aud.sdata, busy, aud.out_rd_en, underflow_cnt}),
                      64'({eb, el, es, ebusy, erd, 16'(m_uf)}));
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          p0;
      int          ones;
      int          n;
      bit          found;
      logic [31:0] l;
      logic [31:0] r;
      logic [15:0] exp_l[64];
      logic [15:0] exp_r[64];

      drive_heads();
      #1;
      check_output("reset_held", 64'({aud.bclk, aud.lrclk, aud.sdata, busy, aud.out_rd_en, underflow_cnt}), 64'(0));
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b0;
      @(negedge clock);
      check_output("reset_state", 64'({aud.bclk, aud.lrclk, aud.sdata, busy, aud.out_rd_en, underflow_cnt}), 64'(0));

      $display("[TB] basic frames, saturation and enable drop");
      apply_stimulus(32'h0000_1234, 32'hFFFF_FF00);
      apply_stimulus(32'h0001_2345, 32'h8000_0000);
      apply_stimulus(32'h0000_7FFF, 32'hFFFF_8000);
      cap.delete();
      p0 = pop_count;
      set_enable(1'b1);
      wait_pops(p0 + 3, 3 * FRAME_CLKS + 20, "three_pops");
      repeat (10) @(negedge clock);
      set_enable(1'b0);
      wait_busy(1'b0, FRAME_CLKS + 20, "idle_after_drop");
      check_output("pop_count_basic", 64'(pop_count - p0), 64'(3));
      if (pop_cycle.size() >= p0 + 3) begin
         check_output("frame_len_1", 64'(pop_cycle[p0+1] - pop_cycle[p0]), 64'(257));
         check_output("frame_len_2", 64'(pop_cycle[p0+2] - pop_cycle[p0+1]), 64'(257));
      end
      check_output("bits_basic", 64'(cap.size()), 64'(96));
      check_frame(0, 16'h1234, 16'hFF00, "frame_plain");
      check_frame(1, 16'h7FFF, 16'h8000, "frame_clip");
      check_frame(2, 16'h7FFF, 16'h8000, "frame_edge");
      repeat (20) @(negedge clock);
      check_output("no_extra_pop", 64'(pop_count - p0), 64'(3));

      $display("[TB] underflow with right FIFO empty");
      lq.push_back(32'h0000_0ABC);
      drive_heads();
      cap.delete();
      p0 = pop_count;
      set_enable(1'b1);
      wait_busy(1'b1, 5, "uf_start");
      repeat (2 * FRAME_CLKS + 20) @(negedge clock);
      set_enable(1'b0);
      wait_busy(1'b0, FRAME_CLKS + 20, "uf_idle");
      check_output("uf_count", 64'(underflow_cnt), 64'(3));
      check_output("uf_no_pop", 64'(pop_count - p0), 64'(0));
      check_output("uf_left_kept", 64'(lq.size()), 64'(1));
      if (lq.size() > 0) check_output("uf_left_word", 64'(lq[0]), 64'h0ABC);
      ones = 0;
      foreach (cap[i]) if (cap[i][0]) ones++;
      check_output("uf_bits", 64'(cap.size()), 64'(96));
      check_output("uf_silence", 64'(ones), 64'(0));
      lq.delete();
      drive_heads();

      $display("[TB] asynchronous reset during right channel");
      apply_stimulus(32'h0000_4000, 32'hFFFF_FFFF);
      set_enable(1'b1);
      found = 1'b0;
      n = 0;
      while (!found && n < FRAME_CLKS + 20) begin
         @(negedge clock);
         n++;
         if (aud.lrclk === 1'b1 && aud.bclk === 1'b1 && aud.sdata === 1'b1) found = 1'b1;
      end
      check_output("reach_shift_r", 64'(found), 64'(1));
      #2;
      reset = 1'b1;
      #1;
      check_output("rst_bclk",  64'(aud.bclk),      64'(0));
      check_output("rst_lrclk", 64'(aud.lrclk),     64'(0));
      check_output("rst_sdata", 64'(aud.sdata),     64'(0));
      check_output("rst_busy",  64'(busy),          64'(0));
      check_output("rst_rd_en", 64'(aud.out_rd_en), 64'(0));
      check_output("rst_uf",    64'(underflow_cnt), 64'(0));
      repeat (2) @(posedge clock);
      #2;
      apply_stimulus(32'h0000_0055, 32'h0000_00AA);
      p0 = pop_count;
      reset = 1'b0;
      @(negedge clock);
      check_output("post_rst_idle", 64'(busy), 64'(0));
      @(negedge clock);
      check_output("post_rst_load", 64'({busy, aud.out_rd_en}), 64'(2'b11));
      set_enable(1'b0);
      wait_busy(1'b0, FRAME_CLKS + 20, "post_rst_done");
      check_output("post_rst_pops", 64'(pop_count - p0), 64'(1));

      $display("[TB] underflow counter saturation");
      @(posedge clock);
      #2;
      force dut.underflow_q = 16'hFFFE;
      m_uf = 65534;
      #1;
      release dut.underflow_q;
      @(negedge clock);
      check_output("uf_preset", 64'(underflow_cnt), 64'hFFFE);
      set_enable(1'b1);
      wait_busy(1'b1, 5, "sat_start");
      repeat (FRAME_CLKS + 20) @(negedge clock);
      set_enable(1'b0);
      wait_busy(1'b0, FRAME_CLKS + 20, "sat_idle");
      check_output("uf_saturated", 64'(underflow_cnt), 64'hFFFF);

      $display("[TB] long run of 64 pairs");
      for (int i = 0; i < 64; i++) begin
         case (i % 4)
            0:       l = 32'h0001_0000 + 32'(i);
            1:       l = 32'hFFFE_0000 - 32'(i * 3);
            2:       l = 32'(i * 509) - 32'd16000;
            default: l = 32'h0000_7FF0 + 32'(i);
         endcase
         r = ~l + 32'(i * 97);
         exp_l[i] = ref_sat(l);
         exp_r[i] = ref_sat(r);
         apply_stimulus(l, r);
      end
      cap.delete();
      p0 = pop_count;
      set_enable(1'b1);
      wait_pops(p0 + 64, 64 * FRAME_CLKS + 50, "long_pops");
      set_enable(1'b0);
      wait_busy(1'b0, FRAME_CLKS + 50, "long_idle");
      check_output("long_pop_count", 64'(pop_count - p0), 64'(64));
      check_output("long_bits", 64'(cap.size()), 64'(64 * 32));
      for (int i = 0; i < 64; i++) check_frame(i, exp_l[i], exp_r[i], "long_frame");
      check_output("long_uf_hold", 64'(underflow_cnt), 64'hFFFF);
      check_output("long_fifo_drained", 64'(lq.size() + rq.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
